// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store constants, FSM states and lane helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] make_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    make_strobe = 4'b0001 << off;
      F3_H:    make_strobe = 4'b0011 << off;
      F3_W:    make_strobe = 4'b1111;
      default: make_strobe = 4'b0000;
    endcase
  endfunction

  // Narrow stores are replicated on every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    lane_data = {4{d[7:0]}};
      F3_H:    lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - aligns the captured bus word and sign/zero-extends it
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'd0, shifted[7:0]};
      F3_HU:   result = {16'd0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-transaction load/store unit on a req/ack bus
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_mem_read,
  input  logic        s_mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        req;
  logic        f3_ok;
  logic        aligned;
  logic        accept;
  logic        reject;
  logic [31:0] ext_data;

  always_comb begin
    req = s_mem_read | s_mem_write;
    case (funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~s_mem_write;
      default:          f3_ok = 1'b0;
    endcase
    case (funct3)
      F3_H, F3_HU: aligned = ~addr[0];
      F3_W:        aligned = (addr[1:0] == 2'b00);
      default:     aligned = 1'b1;
    endcase
    accept = (state == IDLE) && req && f3_ok && aligned;
    reject = (state == IDLE) && req && !(f3_ok && aligned);
  end

  assign stall      = accept || (state == BUSY);
  assign misaligned = reject;
  assign bus_err    = (state == DONE) && err_q;
  assign load_data  = ((state == DONE) && !bus_we) ? ext_data : 32'd0;

  load_extend u_load_extend (
    .word   (rdata_q),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Write wins when both strobes are raised together.
            bus_req   <= 1'b1;
            bus_we    <= s_mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wstrb <= s_mem_write ? make_strobe(funct3, addr[1:0]) : 4'd0;
            bus_wdata <= s_mem_write ? lane_data(funct3, wdata) : 32'd0;
            off_q     <= addr[1:0];
            f3_q      <= funct3;
            cnt       <= 8'd0;
            err_q     <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            bus_req <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          cnt   <= 8'd0;
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven bench for mem_access_unit
module tb_mem_access_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_mem_read, s_mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, misaligned, bus_err;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;

  int n_vec = 0;
  int n_bad = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_mem_read  (s_mem_read),
    .s_mem_write (s_mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .load_data   (load_data),
    .misaligned  (misaligned),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                              input logic mis, input logic [3:0] strb, input logic [31:0] ewd,
                              input logic [31:0] eld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
    v.exp_mis = mis; v.exp_strb = strb; v.exp_wdata = ewd; v.exp_load = eld;
    return v;
  endfunction

  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    s_mem_read = v.rd; s_mem_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    #1;
    chk1($sformatf("v%0d_misaligned", i), misaligned, v.exp_mis);
    chk1($sformatf("v%0d_stall_accept", i), stall, !v.exp_mis);
    @(posedge clk); #1;
    s_mem_read = 1'b0; s_mem_write = 1'b0;
    if (v.exp_mis) begin
      chk1($sformatf("v%0d_no_req", i), bus_req, 1'b0);
      chk1($sformatf("v%0d_no_stall", i), stall, 1'b0);
    end else begin
      chk1($sformatf("v%0d_req", i), bus_req, 1'b1);
      chk1($sformatf("v%0d_stall_busy", i), stall, 1'b1);
      chk1($sformatf("v%0d_we", i), bus_we, v.wr);
      chk($sformatf("v%0d_addr", i), bus_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_wstrb", i), {28'd0, bus_wstrb}, {28'd0, v.exp_strb});
      if (v.wr) chk($sformatf("v%0d_wdata", i), bus_wdata, v.exp_wdata);
      bus_ack = 1'b1; bus_rdata = v.rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'hA5A5_A5A5;
      chk1($sformatf("v%0d_done_stall", i), stall, 1'b0);
      chk1($sformatf("v%0d_done_req", i), bus_req, 1'b0);
      chk1($sformatf("v%0d_done_err", i), bus_err, 1'b0);
      if (!v.wr) chk($sformatf("v%0d_load_data", i), load_data, v.exp_load);
      @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int stall_cnt;
    int req_cnt;

    vecs[0]  = mk(1, 0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(1, 0, F3_B,  32'h103, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(1, 0, F3_BU, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        32'h00000080);
    vecs[3]  = mk(1, 0, F3_H,  32'h102, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        32'hFFFF80FF);
    vecs[4]  = mk(1, 0, F3_HU, 32'h102, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        32'h000080FF);
    vecs[5]  = mk(1, 0, F3_B,  32'h101, 32'h0,        32'h12345678, 0, 4'b0000, 32'h0,        32'h00000056);
    vecs[6]  = mk(1, 0, F3_H,  32'h100, 32'h0,        32'h1234F00D, 0, 4'b0000, 32'h0,        32'hFFFFF00D);
    vecs[7]  = mk(0, 1, F3_B,  32'h201, 32'h12345678, 32'h0,        0, 4'b0010, 32'h78787878, 32'h0);
    vecs[8]  = mk(0, 1, F3_H,  32'h202, 32'h12345678, 32'h0,        0, 4'b1100, 32'h56785678, 32'h0);
    vecs[9]  = mk(0, 1, F3_W,  32'h204, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[10] = mk(0, 1, F3_B,  32'h203, 32'h000000AB, 32'h0,        0, 4'b1000, 32'hABABABAB, 32'h0);
    vecs[11] = mk(1, 1, F3_H,  32'h200, 32'h0000BEEF, 32'h0,        0, 4'b0011, 32'hBEEFBEEF, 32'h0);
    vecs[12] = mk(1, 0, F3_W,  32'h102, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[13] = mk(0, 1, F3_BU, 32'h100, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[14] = mk(1, 0, F3_H,  32'h101, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[15] = mk(1, 0, 3'b011, 32'h100, 32'h0,       32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[16] = mk(0, 1, F3_W,  32'h101, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[17] = mk(1, 0, F3_HU, 32'h103, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);

    rst = 1'b1; s_mem_read = 1'b0; s_mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_misaligned", misaligned, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Load with two extra wait states: 4 stall cycles in total.
    @(negedge clk);
    s_mem_read = 1'b1; funct3 = F3_W; addr = 32'h300;
    stall_cnt = 0;
    #1; if (stall) stall_cnt++;
    @(posedge clk); #1; s_mem_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (k == 2) begin bus_ack = 1'b1; bus_rdata = 32'h0BADF00D; end
      @(posedge clk); #1; bus_ack = 1'b0;
    end
    chk("wait_stall_cycles", stall_cnt, 4);
    chk1("wait_done_stall", stall, 1'b0);
    chk("wait_load_data", load_data, 32'h0BADF00D);
    @(posedge clk);

    // No ack: bus_req must stay up exactly TIMEOUT=4 cycles.
    @(negedge clk);
    s_mem_read = 1'b1; funct3 = F3_W; addr = 32'h400;
    @(posedge clk); #1; s_mem_read = 1'b0;
    req_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus_req) break;
      req_cnt++;
    end
    chk("to_req_cycles", req_cnt, 4);
    chk1("to_bus_err", bus_err, 1'b1);
    chk1("to_stall", stall, 1'b0);
    chk("to_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    chk1("to_idle_bus_err", bus_err, 1'b0);
    chk1("to_idle_stall", stall, 1'b0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk1("spurious_ack_req", bus_req, 1'b0);
    chk1("spurious_ack_err", bus_err, 1'b0);
    chk("spurious_ack_load", load_data, 32'd0);

    // Back-to-back: request held through DONE is taken in the following IDLE cycle.
    @(negedge clk);
    s_mem_read = 1'b1; funct3 = F3_BU; addr = 32'h602;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h00C30000;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk1("b2b_done_stall", stall, 1'b0);
    chk1("b2b_done_req", bus_req, 1'b0);
    chk("b2b_done_load", load_data, 32'h000000C3);
    @(posedge clk); #1;
    chk1("b2b_idle_stall", stall, 1'b1);
    @(posedge clk); #1;
    s_mem_read = 1'b0;
    chk1("b2b_second_req", bus_req, 1'b1);
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("b2b_second_load", load_data, 32'h00000022);
    @(posedge clk);

    // Reset in the second BUSY cycle of a store.
    @(negedge clk);
    s_mem_write = 1'b1; funct3 = F3_W; addr = 32'h500; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1; s_mem_write = 1'b0;
    @(posedge clk); #1;
    chk1("rstbusy_req_before", bus_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("rstbusy_req", bus_req, 1'b0);
    chk1("rstbusy_we", bus_we, 1'b0);
    chk("rstbusy_addr", bus_addr, 32'd0);
    chk("rstbusy_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rstbusy_wdata", bus_wdata, 32'd0);
    chk1("rstbusy_stall", stall, 1'b0);
    chk1("rstbusy_err", bus_err, 1'b0);
    chk("rstbusy_load", load_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("rstbusy_after_err", bus_err, 1'b0);
    chk1("rstbusy_after_req", bus_req, 1'b0);
    chk1("rstbusy_after_stall", stall, 1'b0);
    chk("rstbusy_after_load", load_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
